core_mc_seq: RTL and testbench

- Multi-cycle instruction sequencer for the RV64 core, parametrised in XLEN, address width and reset vector. It replaces the single-cycle "everything in one clock" control.
- It owns the PC, the instruction register (IR) and the memory-data register (MDR). It drives req/ack handshakes to instruction and data memory, so memory may take any number of cycles.
- It gates register-file writeback to one pulse per retired instruction.
- It sits between the RAM and the existing decoder, execute unit and control-flow logic, which stay combinational and are fed from the IR.

---
 rtl/core_mc_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_core_mc_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mc_seq.sv
// ---------------------------------------------------------------------------
// core_mc_seq -- multi-cycle instruction sequencer for the RV64 core.
//
// Owns the PC, the instruction register (IR) and the memory-data register
// (MDR). Instruction and data memory are reached over req/ack handshakes, so
// either memory may take any number of cycles. The decoder, execute unit and
// control-flow logic stay combinational and are fed from the IR. Their
// results are captured in EXEC and used later in MEM and WB.
//
// State flow: FETCH -> EXEC -> (MEM) -> WB -> FETCH | HALT
//
// Optional build macro: CORE_MC_PERF_EN adds the perf_cycles, perf_instret
// and perf_mem_stall counter outputs.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   imem_req/addr       fetch request and address (pc[ADDR_W-1:0])
//   imem_ack/rdata      fetch completion and instruction word
//   dmem_req/we/addr/wdata   data request; addr and wdata registered in EXEC
//   dmem_ack/rdata      data completion and load data
//   ir, pc              instruction register (to decoder) and current PC
//   ex_*                combinational results from decode/execute/control-flow
//   halt_req            stop once the current instruction retires
//   rf_we, rf_wdata     register-file write strobe and data (one pulse in WB)
//   retire              one-cycle pulse per retired instruction
//   halted              high while in HALT
//   result              last value written to the register file
// ---------------------------------------------------------------------------
module core_mc_seq #(
  parameter int                XLEN     = 64,
  parameter int                ADDR_W   = 13,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [31:0]       ir,
  output logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   ex_next_pc,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [XLEN-1:0]   ex_mem_wdata,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_wb_en,
  input  logic              halt_req,
  output logic              rf_we,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              retire,
  output logic              halted,
  output logic [XLEN-1:0]   result
`ifdef CORE_MC_PERF_EN
  ,
  output logic [XLEN-1:0]   perf_cycles,
  output logic [XLEN-1:0]   perf_instret,
  output logic [XLEN-1:0]   perf_mem_stall
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t              state_reg;
  logic [XLEN-1:0]     pc_reg;
  logic [31:0]         ir_reg;
  logic [XLEN-1:0]     mdr_reg;
  logic                imem_req_reg;
  logic                dmem_req_reg;
  logic [XLEN-1:0]     next_pc_reg;
  logic [XLEN-1:0]     ex_result_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [XLEN-1:0]     mem_wdata_reg;
  logic                is_load_reg;
  logic                is_store_reg;
  logic                wb_en_reg;
  logic                halt_pend_reg;
  logic [XLEN-1:0]     result_reg;
  logic [XLEN-1:0]     wb_data;

  // Writeback data depends only on registered state, never on live inputs.
  assign wb_data = is_load_reg ? mdr_reg : ex_result_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_FETCH;
      pc_reg        <= RESET_PC;
      ir_reg        <= NOP;
      mdr_reg       <= '0;
      imem_req_reg  <= 1'b0;
      dmem_req_reg  <= 1'b0;
      next_pc_reg   <= '0;
      ex_result_reg <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      is_load_reg   <= 1'b0;
      is_store_reg  <= 1'b0;
      wb_en_reg     <= 1'b0;
      halt_pend_reg <= 1'b0;
      result_reg    <= '0;
    end else begin
      // A halt request seen before WB is remembered so it still applies
      // even if the requester has already let go of it.
      if (halt_req && state_reg != ST_HALT)
        halt_pend_reg <= 1'b1;

      case (state_reg)
        ST_FETCH: begin
          // Request goes out the cycle after entry; an ack while no request
          // is outstanding is ignored.
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (imem_ack) begin
            ir_reg       <= imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          next_pc_reg   <= ex_next_pc;
          ex_result_reg <= ex_result;
          mem_addr_reg  <= ex_mem_addr;
          mem_wdata_reg <= ex_mem_wdata;
          // Store wins when both flags are set.
          is_store_reg  <= ex_is_store;
          is_load_reg   <= ex_is_load & ~ex_is_store;
          wb_en_reg     <= ex_wb_en;
          state_reg     <= (ex_is_load || ex_is_store) ? ST_MEM : ST_WB;
        end

        ST_MEM: begin
          if (!dmem_req_reg) begin
            dmem_req_reg <= 1'b1;
          end else if (dmem_ack) begin
            if (is_load_reg)
              mdr_reg <= dmem_rdata;
            dmem_req_reg <= 1'b0;
            state_reg    <= ST_WB;
          end
        end

        ST_WB: begin
          pc_reg <= next_pc_reg;
          if (wb_en_reg)
            result_reg <= wb_data;
          if (halt_req || halt_pend_reg) begin
            state_reg <= ST_HALT;
          end else begin
            state_reg <= ST_FETCH;
          end
          halt_pend_reg <= 1'b0;
        end

        ST_HALT: begin
          state_reg <= ST_HALT;
        end

        default: begin
          state_reg <= ST_FETCH;
        end
      endcase
    end
  end

  // All outputs come from registers or from a state decode.
  assign imem_req   = imem_req_reg;
  assign imem_addr  = pc_reg[ADDR_W-1:0];
  assign dmem_req   = dmem_req_reg;
  assign dmem_we    = dmem_req_reg & is_store_reg;
  assign dmem_addr  = mem_addr_reg;
  assign dmem_wdata = mem_wdata_reg;
  assign ir         = ir_reg;
  assign pc         = pc_reg;
  assign rf_we      = (state_reg == ST_WB) & wb_en_reg;
  assign rf_wdata   = wb_data;
  assign retire     = (state_reg == ST_WB);
  assign halted     = (state_reg == ST_HALT);
  assign result     = result_reg;

`ifdef CORE_MC_PERF_EN
  logic [XLEN-1:0] perf_cycles_reg;
  logic [XLEN-1:0] perf_instret_reg;
  logic [XLEN-1:0] perf_mem_stall_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles_reg    <= '0;
      perf_instret_reg   <= '0;
      perf_mem_stall_reg <= '0;
    end else begin
      if (state_reg != ST_HALT)
        perf_cycles_reg <= perf_cycles_reg + 1'b1;
      if (state_reg == ST_WB)
        perf_instret_reg <= perf_instret_reg + 1'b1;
      if ((imem_req_reg && !imem_ack) || (dmem_req_reg && !dmem_ack))
        perf_mem_stall_reg <= perf_mem_stall_reg + 1'b1;
    end
  end

  assign perf_cycles    = perf_cycles_reg;
  assign perf_instret   = perf_instret_reg;
  assign perf_mem_stall = perf_mem_stall_reg;
`endif

endmodule

// File: tb/tb_core_mc_seq.sv
// ---------------------------------------------------------------------------
// tb_core_mc_seq -- directed self-checking bench for core_mc_seq.
// The bench plays both memories and the combinational datapath. It keeps its
// own PC and result model and checks every handshake and writeback.
// ---------------------------------------------------------------------------
module tb_core_mc_seq;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 13;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic [31:0]       ir;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   ex_next_pc;
  logic [XLEN-1:0]   ex_result;
  logic [ADDR_W-1:0] ex_mem_addr;
  logic [XLEN-1:0]   ex_mem_wdata;
  logic              ex_is_load;
  logic              ex_is_store;
  logic              ex_wb_en;
  logic              halt_req;
  logic              rf_we;
  logic [XLEN-1:0]   rf_wdata;
  logic              retire;
  logic              halted;
  logic [XLEN-1:0]   result;
`ifdef CORE_MC_PERF_EN
  logic [XLEN-1:0]   perf_cycles;
  logic [XLEN-1:0]   perf_instret;
  logic [XLEN-1:0]   perf_mem_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] pc_model;
  logic [63:0] result_model;

  core_mc_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .ir           (ir),
    .pc           (pc),
    .ex_next_pc   (ex_next_pc),
    .ex_result    (ex_result),
    .ex_mem_addr  (ex_mem_addr),
    .ex_mem_wdata (ex_mem_wdata),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_wb_en     (ex_wb_en),
    .halt_req     (halt_req),
    .rf_we        (rf_we),
    .rf_wdata     (rf_wdata),
    .retire       (retire),
    .halted       (halted),
    .result       (result)
`ifdef CORE_MC_PERF_EN
    ,
    .perf_cycles    (perf_cycles),
    .perf_instret   (perf_instret),
    .perf_mem_stall (perf_mem_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_next_pc   = '0;
    ex_result    = '0;
    ex_mem_addr  = '0;
    ex_mem_wdata = '0;
    ex_is_load   = 1'b0;
    ex_is_store  = 1'b0;
    ex_wb_en     = 1'b0;
  endtask

  // Run one instruction from FETCH entry through WB. Called 1 ns after the
  // edge that entered FETCH. hlt raises halt_req in MEM (memory ops) or WB.
  task automatic run_instr(input string name, input logic [31:0] instr, input int fwait,
                           input logic [63:0] nxt, input logic [63:0] res,
                           input logic [12:0] maddr, input logic [63:0] mwdata,
                           input logic ld, input logic st, input logic wb,
                           input int mwait, input logic [63:0] mrdata, input logic hlt);
    logic [63:0] exp_wd;
    exp_wd = (ld && !st) ? mrdata : res;

    check_val({name, "_req_idle"}, {63'd0, imem_req}, 64'd0);
    tick();
    check_val({name, "_imem_req"}, {63'd0, imem_req}, 64'd1);
    check_val({name, "_imem_addr"}, {51'd0, imem_addr}, {51'd0, pc_model[12:0]});
    for (int i = 0; i < fwait; i++) begin
      tick();
      check_val({name, "_imem_addr_hold"}, {50'd0, imem_req, imem_addr}, {50'd0, 1'b1, pc_model[12:0]});
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    check_val({name, "_ir"}, {32'd0, ir}, {32'd0, instr});
    check_val({name, "_req_drop"}, {63'd0, imem_req}, 64'd0);
    check_val({name, "_exec_no_wb"}, {62'd0, rf_we, retire}, 64'd0);

    // EXEC: datapath presents its results for the new IR.
    ex_next_pc   = nxt;
    ex_result    = res;
    ex_mem_addr  = maddr;
    ex_mem_wdata = mwdata;
    ex_is_load   = ld;
    ex_is_store  = st;
    ex_wb_en     = wb;
    tick();
    clear_ex();

    if (ld || st) begin
      check_val({name, "_dmem_idle"}, {63'd0, dmem_req}, 64'd0);
      if (hlt) halt_req = 1'b1;
      tick();
      for (int i = 0; i <= mwait; i++) begin
        check_val({name, "_dmem_req"}, {62'd0, dmem_req, dmem_we}, {62'd0, 1'b1, st});
        check_val({name, "_dmem_addr"}, {51'd0, dmem_addr}, {51'd0, maddr});
        if (st) check_val({name, "_dmem_wdata"}, dmem_wdata, mwdata);
        if (i == mwait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = mrdata;
        end
        tick();
      end
      dmem_ack   = 1'b0;
      dmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
      check_val({name, "_dmem_drop"}, {63'd0, dmem_req}, 64'd0);
    end else if (hlt) begin
      halt_req = 1'b1;
    end

    // WB
    check_val({name, "_rf_we"}, {63'd0, rf_we}, {63'd0, wb});
    if (wb) check_val({name, "_rf_wdata"}, rf_wdata, exp_wd);
    check_val({name, "_retire"}, {63'd0, retire}, 64'd1);
    tick();
    halt_req = 1'b0;
    pc_model = nxt;
    if (wb) result_model = exp_wd;
    check_val({name, "_post_strobes"}, {62'd0, rf_we, retire}, 64'd0);
    check_val({name, "_pc"}, pc, pc_model);
    check_val({name, "_result"}, result, result_model);
    check_val({name, "_halted"}, {63'd0, halted}, {63'd0, hlt});
    $display("instr %-8s ir=%h pc=%h result=%h halted=%0d", name, instr, pc, result, halted);
  endtask

  initial begin
    logic saw_req;

    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    halt_req   = 1'b0;
    clear_ex();
    pc_model     = 64'h0;
    result_model = 64'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_reqs", {62'd0, imem_req, dmem_req}, 64'd0);
    check_val("rst_pc", pc, 64'h0);
    check_val("rst_ir", {32'd0, ir}, 64'h13);
    check_val("rst_result", result, 64'h0);
    check_val("rst_flags", {61'd0, halted, rf_we, retire}, 64'd0);
    $display("reset checked pc=%h ir=%h", pc, ir);
    rst = 1'b1;

    // addi x1,x0,5 at zero wait
    run_instr("addi", 32'h0050_0093, 0, 64'h4, 64'h5, 13'h0, 64'h0,
              1'b0, 1'b0, 1'b1, 0, 64'h0, 1'b0);
    // Load, ack three cycles after request
    run_instr("ld", 32'h1000_3083, 1, 64'h8, 64'h0, 13'h0100, 64'h0,
              1'b1, 1'b0, 1'b1, 3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    // Store
    run_instr("sd", 32'h0020_3423, 2, 64'hC, 64'h99, 13'h0008, 64'h1234,
              1'b0, 1'b1, 1'b0, 0, 64'h0, 1'b0);
    // Taken branch, no writeback
    run_instr("beq", 32'h0200_0863, 0, 64'h40, 64'h77, 13'h0, 64'h0,
              1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
    // Both load and store flagged: must behave as a store
    run_instr("ldst", 32'h0050_3023, 0, 64'h44, 64'h0, 13'h1FFF, 64'h55,
              1'b1, 1'b1, 1'b0, 0, 64'h0, 1'b0);
    // Load with halt requested during MEM
    run_instr("ld_halt", 32'h0000_3103, 0, 64'h48, 64'h0, 13'h0010, 64'h0,
              1'b1, 1'b0, 1'b1, 1, 64'h777, 1'b1);

    saw_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req || dmem_req || !halted) saw_req = 1'b1;
    end
    check_val("halt_quiet", {63'd0, saw_req}, 64'd0);
    check_val("halt_pc", pc, 64'h48);
    $display("halt held 20 cycles pc=%h", pc);

    // Leave HALT by reset, then pulse reset mid-fetch
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    check_val("refetch_req", {63'd0, imem_req}, 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check_val("async_req_drop", {63'd0, imem_req}, 64'd0);
    check_val("async_pc", pc, 64'h0);
    check_val("async_halted", {63'd0, halted}, 64'd0);
    @(negedge clk);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    tick();
    check_val("stray_ack_ir", {32'd0, ir}, 64'h13);
    check_val("restart_req", {51'd0, imem_req, imem_addr}, {51'd0, 1'b1, 13'h0});
    imem_rdata = 32'h0010_0093;
    tick();
    imem_ack = 1'b0;
    check_val("restart_ir", {32'd0, ir}, 64'h0010_0093);
    $display("reset mid-fetch recovered ir=%h pc=%h", ir, pc);

`ifdef CORE_MC_PERF_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    pc_model     = 64'h0;
    result_model = 64'h0;
    run_instr("p_add1", 32'h0010_0093, 0, 64'h4, 64'h1, 13'h0, 64'h0,
              1'b0, 1'b0, 1'b1, 0, 64'h0, 1'b0);
    run_instr("p_add2", 32'h0020_0093, 0, 64'h8, 64'h2, 13'h0, 64'h0,
              1'b0, 1'b0, 1'b1, 0, 64'h0, 1'b0);
    run_instr("p_add3", 32'h0030_0093, 0, 64'hC, 64'h3, 13'h0, 64'h0,
              1'b0, 1'b0, 1'b1, 0, 64'h0, 1'b1);
    repeat (3) tick();
    check_val("perf_instret", perf_instret, 64'd3);
    check_val("perf_cycles", perf_cycles, 64'd12);
    check_val("perf_mem_stall", perf_mem_stall, 64'd0);
    $display("perf cycles=%0d instret=%0d stall=%0d", perf_cycles, perf_instret, perf_mem_stall);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
